// File: rtl/dataacc_pkg.sv
// Shared register map, bit positions and scheduler state encoding for the
// accelerator-matrix port scheduler.
package dataacc_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_HOLD   = 2'd3;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_TMO_BIT   = 3;
  localparam int unsigned STAT_BUSY_BIT  = 4;
  localparam int unsigned STAT_LEVEL_LSB = 8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;

endpackage

// File: rtl/dataacc_fifo.sv
// Synchronous word FIFO with flush; a push while full is accepted only when
// a pop happens in the same cycle, otherwise it is dropped and flagged.
module dataacc_fifo #(
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH),
  localparam int unsigned LEVEL_W   = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               pop,
  input  logic               flush,
  output logic [DATA_W-1:0]  rdata,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] count_q;
  logic               do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == LEVEL_W'(FIFO_DEPTH));
  assign level    = count_q;
  assign rdata    = mem[rd_ptr_q];
  // Flush discards everything, including a push arriving in the same cycle.
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && !flush && (!full || do_pop);
  assign overflow = push && !flush && full && !do_pop;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dataacc_port_scheduler.sv
// Avalon-MM command queue feeding the accelerator matrix one word at a time
// with a programmable inter-word gap. Optional ack timeout: DATAACC_TIMEOUT_EN.
module dataacc_port_scheduler
  import dataacc_pkg::*;
#(
  parameter int unsigned DATA_W         = 20,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned HOLD_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ack
);

  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic wr_en, data_wr, status_wr, ctrl_wr, hold_wr, flush;

  assign wr_en     = chipselect && !write_n;
  assign data_wr   = wr_en && (address == ADDR_DATA);
  assign status_wr = wr_en && (address == ADDR_STATUS);
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign hold_wr   = wr_en && (address == ADDR_HOLD);
  assign flush     = ctrl_wr && writedata[CTRL_FLUSH_BIT];

  logic              push_q;
  logic [DATA_W-1:0] push_data_q;
  logic              enable_q, ovf_q;
  logic [HOLD_W-1:0] hold_q;
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] gap_q, gap_d;
  logic [DATA_W-1:0] out_port_q;

  logic               fifo_pop, fifo_full, fifo_empty, fifo_overflow;
  logic [DATA_W-1:0]  fifo_rdata;
  logic [LEVEL_W-1:0] fifo_level;
  logic               tmo_hit, tmo_flag;
  logic [31:0]        status;

  // Bus writes are registered before entering the queue, so a DATA write
  // reaches the port two edges after it is sampled.
  dataacc_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_q),
    .wdata   (push_data_q),
    .pop     (fifo_pop),
    .flush   (flush),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .overflow(fifo_overflow)
  );

`ifdef DATAACC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_flag_q;

  assign tmo_hit  = (state_q == PRESENT) && !out_ack
                    && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_flag = tmo_flag_q;

  always_ff @(posedge clk) begin
    if (reset || fifo_pop) tmo_cnt_q <= '0;
    else if (state_q == PRESENT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_flag_q <= 1'b0;
    else if (tmo_hit) tmo_flag_q <= 1'b1;
    else if (status_wr && writedata[STAT_TMO_BIT]) tmo_flag_q <= 1'b0;
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    fifo_pop = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = PRESENT;
          end
        end
        PRESENT: begin
          if (out_ack) begin
            gap_d   = hold_q;
            state_d = (hold_q != '0) ? GAP : IDLE;
          end else if (tmo_hit) begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (gap_q <= HOLD_W'(1)) state_d = IDLE;
          else gap_d = gap_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      out_port_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      enable_q    <= 1'b0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      push_q      <= data_wr;
      push_data_q <= writedata[DATA_W-1:0];
      if (fifo_pop) out_port_q <= fifo_rdata;
      if (ctrl_wr) enable_q <= writedata[CTRL_EN_BIT];
      if (hold_wr) hold_q <= writedata[HOLD_W-1:0];
      // A new overflow wins over a simultaneous software clear.
      if (fifo_overflow) ovf_q <= 1'b1;
      else if (status_wr && writedata[STAT_OVF_BIT]) ovf_q <= 1'b0;
    end
  end

  assign out_port  = out_port_q;
  assign out_valid = (state_q == PRESENT);

  always_comb begin
    status                          = '0;
    status[STAT_EMPTY_BIT]          = fifo_empty;
    status[STAT_FULL_BIT]           = fifo_full;
    status[STAT_OVF_BIT]            = ovf_q;
    status[STAT_TMO_BIT]            = tmo_flag;
    status[STAT_BUSY_BIT]           = (state_q != IDLE);
    status[STAT_LEVEL_LSB +: 8]     = 8'(fifo_level);
    case (address)
      ADDR_DATA:   readdata = 32'(out_port_q);
      ADDR_STATUS: readdata = status;
      ADDR_CTRL:   readdata = {31'b0, enable_q};
      default:     readdata = 32'(hold_q);
    endcase
  end

endmodule
